// File: rtl/amiga_bus_pkg.sv
// rtl/amiga_bus_pkg.sv - shared types and constants for the Amiga bus-cycle controllers
package amiga_bus_pkg;

   typedef enum logic [2:0] {
      IDLE,
      DECODE,
      WAIT,
      ACK,
      FOREIGN
   } state_t;

   localparam logic [4:0] ROM_HI_MATCH = 5'b11111;
   localparam logic [4:0] ROM_LO_MATCH = 5'b00000;

   // Counter width able to hold 0..t inclusive.
   function automatic int cnt_width(input int t);
      return $clog2(t + 1);
   endfunction

endpackage

// File: rtl/amiga_bus_watchdog.sv
// rtl/amiga_bus_watchdog.sv - bus-cycle watchdog: counts unacknowledged _AS clocks, drives _BERR
module amiga_bus_watchdog
   import amiga_bus_pkg::*;
#(
   parameter int TIMEOUT = 64
) (
   input  logic clk,
   input  logic rst_n,
   input  logic as_n,
   input  logic dtack_in_n,
   input  logic dtack_n,
   output logic berr_n
);

   localparam int CW = cnt_width(TIMEOUT);

   logic [CW-1:0] cnt;

   // Any DTACK freezes the count, so an acknowledge on the would-be timeout clock wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         berr_n <= 1'b1;
      end else if (as_n) begin
         cnt    <= '0;
         berr_n <= 1'b1;
      end else if (dtack_in_n && dtack_n && (cnt != CW'(TIMEOUT))) begin
         cnt <= cnt + 1'b1;
         if (cnt == CW'(TIMEOUT - 1))
            berr_n <= 1'b0;
      end
   end

endmodule

// File: rtl/amiga_rom_cycle_ctrl.sv
// rtl/amiga_rom_cycle_ctrl.sv - 68000 bus-cycle sequencer for Kickstart ROM: decode, wait states,
// ROM output enable, DTACK and watchdog bus error
module amiga_rom_cycle_ctrl
   import amiga_bus_pkg::*;
#(
   parameter int ROM_WAIT = 2,
   parameter int TIMEOUT  = 64
) (
   input  logic       CLK,
   input  logic       _RESET,
   input  logic [4:0] A,
   input  logic       _AS,
   input  logic       RW,
   input  logic       OVL,
   input  logic       _OVR,
   input  logic       XRDY,
   input  logic       _DTACK_IN,
   output logic       _ROME,
   output logic       _RE,
   output logic       _DTACK,
   output logic       _DAE,
   output logic       _BERR
);

   localparam int CW = cnt_width(TIMEOUT);

   state_t        state, state_nx;
   logic [CW-1:0] wait_cnt, wait_cnt_nx;
   logic          rome_n, rome_nx;
   logic          re_n, re_nx;
   logic          dtack_n, dtack_nx;
   logic          dae_n, dae_nx;
   logic          berr_n;
   logic          hit;

   assign hit = ~_AS & _OVR & ((A == ROM_HI_MATCH) | ((A == ROM_LO_MATCH) & OVL));

   always_ff @(posedge CLK or negedge _RESET) begin
      if (!_RESET) begin
         state    <= IDLE;
         wait_cnt <= '0;
         rome_n   <= 1'b1;
         re_n     <= 1'b1;
         dtack_n  <= 1'b1;
         dae_n    <= 1'b1;
      end else begin
         state    <= state_nx;
         wait_cnt <= wait_cnt_nx;
         rome_n   <= rome_nx;
         re_n     <= re_nx;
         dtack_n  <= dtack_nx;
         dae_n    <= dae_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      wait_cnt_nx = wait_cnt;
      rome_nx     = rome_n;
      re_nx       = re_n;
      dtack_nx    = dtack_n;
      dae_nx      = dae_n;
      case (state)
         IDLE: begin
            if (!_AS)
               state_nx = DECODE;
         end
         DECODE: begin
            if (_AS) begin
               state_nx = IDLE;
            end else if (hit) begin
               state_nx    = WAIT;
               wait_cnt_nx = CW'(ROM_WAIT);
               rome_nx     = 1'b0;
               re_nx       = ~RW;
            end else begin
               state_nx = FOREIGN;
            end
         end
         WAIT: begin
            // Abort beats override; both release the ROM without acknowledging.
            if (_AS) begin
               state_nx = IDLE;
               rome_nx  = 1'b1;
               re_nx    = 1'b1;
            end else if (!_OVR) begin
               state_nx = FOREIGN;
               rome_nx  = 1'b1;
               re_nx    = 1'b1;
            end else if (XRDY) begin
               if (wait_cnt == '0) begin
                  state_nx = ACK;
                  dtack_nx = 1'b0;
                  dae_nx   = 1'b0;
               end else begin
                  wait_cnt_nx = wait_cnt - 1'b1;
               end
            end
         end
         ACK: begin
            if (_AS) begin
               state_nx = IDLE;
               rome_nx  = 1'b1;
               re_nx    = 1'b1;
               dtack_nx = 1'b1;
               dae_nx   = 1'b1;
            end
         end
         FOREIGN: begin
            if (_AS)
               state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   amiga_bus_watchdog #(
      .TIMEOUT(TIMEOUT)
   ) u_watchdog (
      .clk       (CLK),
      .rst_n     (_RESET),
      .as_n      (_AS),
      .dtack_in_n(_DTACK_IN),
      .dtack_n   (dtack_n),
      .berr_n    (berr_n)
   );

   assign _ROME  = rome_n;
   assign _RE    = re_n;
   assign _DTACK = dtack_n;
   assign _DAE   = dae_n;
   assign _BERR  = berr_n;

endmodule
